// File: rtl/rx_align_pkg.sv
// Shared frame-alignment definitions: FSM states, offset-width helper and the
// default frame constants also used by the TX frame builder.
package rx_align_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam logic [7:0] DEF_HEADER      = 8'h5C;
  localparam int         DEF_FRAME_WORDS = 4;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/hdr_search.sv
// Parallel header compare at every bit offset of the alignment window, with a
// lowest-offset priority encoder.
module hdr_search
  import rx_align_pkg::*;
#(
  parameter int               WORDWIDTH = 32,
  parameter int               HDR_W     = 8,
  parameter logic [HDR_W-1:0] HEADER    = HDR_W'(DEF_HEADER)
) (
  input  logic [WORDWIDTH+HDR_W-2:0]    win_i,
  output logic [WORDWIDTH-1:0]          match_o,
  output logic [clog2(WORDWIDTH)-1:0]   idx_o,
  output logic                          found_o
);

  localparam int OFFW = clog2(WORDWIDTH);

  always_comb begin
    match_o = '0;
    for (int k = 0; k < WORDWIDTH; k++) begin
      match_o[k] = (win_i[k +: HDR_W] == HEADER);
    end
  end

  // Scan downwards so the lowest matching offset is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = WORDWIDTH - 1; k >= 0; k--) begin
      if (match_o[k]) begin
        idx_o   = OFFW'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_frame_aligner.sv
// Frame/bit aligner behind the Descrambler: hunts for the periodic header,
// verifies and locks. Optional counters via RX_FRAME_ALIGNER_STATS_EN.
module rx_frame_aligner
  import rx_align_pkg::*;
#(
  parameter int               WORDWIDTH   = 32,
  parameter int               HDR_W       = 8,
  parameter logic [HDR_W-1:0] HEADER      = HDR_W'(DEF_HEADER),
  parameter int               FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int               LOCK_CNT    = 4,
  parameter int               UNLOCK_CNT  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WORDWIDTH-1:0]          din,
  input  logic                          din_valid,
  input  logic                          bypass,
  output logic [WORDWIDTH-1:0]          dout,
  output logic                          dout_valid,
  output logic                          frame_start,
  output logic                          locked,
`ifdef RX_FRAME_ALIGNER_STATS_EN
  output logic [15:0]                   bad_hdr_cnt,
  output logic [15:0]                   lock_loss_cnt,
`endif
  output logic [clog2(WORDWIDTH)-1:0]   offset
);

  localparam int OFFW = clog2(WORDWIDTH);

  align_state_e           state_q, state_d;
  logic [WORDWIDTH-1:0]   prev_q;
  logic [OFFW-1:0]        offset_q, offset_d;
  logic [7:0]             word_cnt_q, word_cnt_d;
  logic [3:0]             good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic                   locked_q, locked_d;
  logic                   frame_start_q, frame_start_d;
  logic [WORDWIDTH-1:0]   dout_q, dout_d;
  logic                   dout_valid_q;

  logic [2*WORDWIDTH-1:0] win;
  logic [WORDWIDTH-1:0]   match;
  logic [OFFW-1:0]        hit_idx;
  logic                   hit_found;
  logic                   slot, hdr_ok, unlock;
  logic [3:0]             good_inc, bad_inc;

  assign win = {din, prev_q};

  hdr_search #(
    .WORDWIDTH (WORDWIDTH),
    .HDR_W     (HDR_W),
    .HEADER    (HEADER)
  ) u_hdr_search (
    .win_i   (win[WORDWIDTH+HDR_W-2:0]),
    .match_o (match),
    .idx_o   (hit_idx),
    .found_o (hit_found)
  );

  assign slot     = (word_cnt_q == 8'(FRAME_WORDS - 1));
  assign hdr_ok   = match[offset_q];
  assign good_inc = (good_cnt_q == 4'hF) ? 4'hF : good_cnt_q + 4'd1;
  assign bad_inc  = (bad_cnt_q == 4'hF) ? 4'hF : bad_cnt_q + 4'd1;
  assign unlock   = (bad_inc >= 4'(UNLOCK_CNT));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d       = state_q;
    offset_d      = offset_q;
    word_cnt_d    = word_cnt_q;
    good_cnt_d    = good_cnt_q;
    bad_cnt_d     = bad_cnt_q;
    locked_d      = locked_q;
    frame_start_d = 1'b0;
    dout_d        = dout_q;
    if (bypass) begin
      state_d    = HUNT;
      offset_d   = '0;
      word_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      locked_d   = 1'b0;
      if (din_valid) dout_d = din;
    end else if (din_valid) begin
      dout_d = win[offset_q +: WORDWIDTH];
      case (state_q)
        HUNT: begin
          if (hit_found) begin
            offset_d   = hit_idx;
            word_cnt_d = '0;
            good_cnt_d = 4'd1;
            state_d    = VERIFY;
          end
        end
        VERIFY: begin
          word_cnt_d = slot ? 8'd0 : word_cnt_q + 8'd1;
          if (slot && hdr_ok) begin
            good_cnt_d = good_inc;
            if (good_inc >= 4'(LOCK_CNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else if (slot) begin
            state_d    = HUNT;
            good_cnt_d = '0;
            word_cnt_d = '0;
          end
        end
        LOCKED: begin
          word_cnt_d = slot ? 8'd0 : word_cnt_q + 8'd1;
          if (slot && hdr_ok) begin
            bad_cnt_d     = '0;
            frame_start_d = 1'b1;
          end else if (slot && unlock) begin
            state_d    = HUNT;
            locked_d   = 1'b0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            word_cnt_d = '0;
          end else if (slot) begin
            bad_cnt_d     = bad_inc;
            frame_start_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      offset_q      <= '0;
      word_cnt_q    <= '0;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      offset_q      <= offset_d;
      word_cnt_q    <= word_cnt_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      dout_q        <= dout_d;
      dout_valid_q  <= din_valid;
      if (din_valid) prev_q <= din;
    end
  end

`ifdef RX_FRAME_ALIGNER_STATS_EN
  logic [15:0] bad_hdr_cnt_q, lock_loss_cnt_q;
  logic        bad_evt, loss_evt;

  assign bad_evt  = !bypass && din_valid && (state_q == LOCKED) && slot && !hdr_ok;
  assign loss_evt = bad_evt && unlock;

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_hdr_cnt_q   <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      if (bad_evt && (bad_hdr_cnt_q != 16'hFFFF)) bad_hdr_cnt_q <= bad_hdr_cnt_q + 16'd1;
      if (loss_evt && (lock_loss_cnt_q != 16'hFFFF)) lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
    end
  end

  assign bad_hdr_cnt   = bad_hdr_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;
`endif

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign offset      = offset_q;

endmodule

// File: tb/tb_rx_frame_aligner.sv
// Directed bench for rx_frame_aligner: reset, lock, loss tolerance, unlock and
// re-acquire, false header, valid gaps, bypass and re-lock.
module tb_rx_frame_aligner;

  localparam logic [7:0] HDR     = 8'h5C;
  localparam logic [7:0] BAD_HDR = 8'h4C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        bypass = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        frame_start;
  logic        locked;
  logic [4:0]  offset;
`ifdef RX_FRAME_ALIGNER_STATS_EN
  logic [15:0] bad_hdr_cnt;
  logic [15:0] lock_loss_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_w = '0;
  logic [63:0] win_m = '0;

  always #5 clk = ~clk;

  rx_frame_aligner dut (
    .clk           (clk),
    .reset         (reset),
    .din           (din),
    .din_valid     (din_valid),
    .bypass        (bypass),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .frame_start   (frame_start),
    .locked        (locked),
`ifdef RX_FRAME_ALIGNER_STATS_EN
    .bad_hdr_cnt   (bad_hdr_cnt),
    .lock_loss_cnt (lock_loss_cnt),
`endif
    .offset        (offset)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload has no two adjacent ones, so 5C can only appear where inserted.
  function automatic logic [31:0] mk_word(input int pos, input logic [7:0] h, input bit put);
    logic [31:0] w;
    w = $urandom & 32'h5555_5555;
    if (put) w[pos +: 8] = h;
    return w;
  endfunction

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    win_m  = {w, last_w};
    last_w = w;
  endtask

  task automatic idle();
    @(negedge clk);
    din       = $urandom;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    bypass    = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    last_w = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int at;

    // Reset and idle
    do_reset(3);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_offset", offset, 0);
    check("rst_frame_start", frame_start, 0);
    release_reset();

    // Clean lock at bit 13, two tolerated bad headers, three bad headers
    // to unlock, then the stream shifts to bit 5 and re-locks.
    for (int n = 0; n < 62; n++) begin
      int          pos;
      logic [7:0]  h;
      int          exp_off;
      bit          exp_lk, exp_fs;
      pos = (n < 44) ? 13 : 5;
      h   = (n == 20 || n == 24 || n == 32 || n == 36 || n == 40) ? BAD_HDR : HDR;
      send(mk_word(pos, h, (n % 4) == 0));
      exp_off = (n == 0) ? 0 : (n < 45) ? 13 : 5;
      exp_lk  = (n >= 13 && n <= 40) || (n >= 57);
      exp_fs  = ((n % 4) == 1) && ((n >= 17 && n <= 37) || n >= 61);
      check($sformatf("offset@%0d", n), offset, exp_off);
      check($sformatf("locked@%0d", n), locked, exp_lk);
      check($sformatf("frame_start@%0d", n), frame_start, exp_fs);
      check($sformatf("dout_valid@%0d", n), dout_valid, 1);
      if (exp_fs) check($sformatf("fs_dout@%0d", n), dout, 32'(win_m >> exp_off));
      if (n == 17 || n == 61) check($sformatf("fs_hdr_byte@%0d", n), dout[7:0], HDR);
`ifdef RX_FRAME_ALIGNER_STATS_EN
      if (n == 25) check("bad_hdr_cnt_tol", bad_hdr_cnt, 2);
      if (n == 41) begin
        check("bad_hdr_cnt_loss", bad_hdr_cnt, 5);
        check("lock_loss_cnt", lock_loss_cnt, 1);
      end
`endif
    end

    // Reset while locked drops everything immediately
    do_reset(1);
    check("midrst_locked", locked, 0);
    check("midrst_dout", dout, 0);
    check("midrst_dout_valid", dout_valid, 0);
    check("midrst_offset", offset, 0);
    check("midrst_frame_start", frame_start, 0);
`ifdef RX_FRAME_ALIGNER_STATS_EN
    check("midrst_lock_loss_cnt", lock_loss_cnt, 0);
`endif
    release_reset();

    // False header at bit 9 of word 3, real stream at bit 13 from word 10
    for (int n = 0; n < 24; n++) begin
      logic [31:0] w;
      if (n == 3) w = mk_word(9, HDR, 1'b1);
      else        w = mk_word(13, HDR, (n >= 10) && (((n - 10) % 4) == 0));
      send(w);
      if (n == 4)  check("false_acq_offset", offset, 9);
      if (n == 11) check("rehunt_offset", offset, 13);
      check($sformatf("false_locked@%0d", n), locked, n == 23);
    end

    // Valid gaps: every valid word followed by an idle cycle
    do_reset(2);
    release_reset();
    for (int n = 0; n < 18; n++) begin
      send(mk_word(13, HDR, (n % 4) == 0));
      check($sformatf("gap_dv@%0d", n), dout_valid, 1);
      check($sformatf("gap_locked@%0d", n), locked, n >= 13);
      check($sformatf("gap_fs@%0d", n), frame_start, n == 17);
      if (n == 1) check("gap_offset", offset, 13);
      idle();
      check($sformatf("gap_idle_dv@%0d", n), dout_valid, 0);
      check($sformatf("gap_idle_fs@%0d", n), frame_start, 0);
      check($sformatf("gap_idle_locked@%0d", n), locked, n >= 13);
    end

    // Bypass: dout follows din one valid cycle later, no lock
    bypass = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = mk_word(0, HDR, 1'b0);
      send(w);
      check($sformatf("byp_dout@%0d", i), dout, w);
      check($sformatf("byp_dv@%0d", i), dout_valid, 1);
      check($sformatf("byp_locked@%0d", i), locked, 0);
      check($sformatf("byp_offset@%0d", i), offset, 0);
      check($sformatf("byp_fs@%0d", i), frame_start, 0);
      if (i == 1) begin
        idle();
        check("byp_idle_dv", dout_valid, 0);
        check("byp_idle_hold", dout, w);
      end
    end

    // Leaving bypass restarts the hunt and must re-lock within 4 frames
    bypass = 1'b0;
    seen   = 1'b0;
    at     = -1;
    for (int n = 0; n < 20; n++) begin
      send(mk_word(13, HDR, (n % 4) == 0));
      if (locked === 1'b1 && !seen) begin
        seen = 1'b1;
        at   = n;
      end
    end
    check("relock_seen", seen, 1);
    check("relock_word", at, 13);
    check("relock_offset", offset, 13);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
